matrix_writer: RTL and testbench

- Initiator-side store engine: takes a stream of 32-bit result elements (shortreal bit patterns) and writes one matrix image into word-addressed memory over the read/write/address/writedata interface used by the M10K wrapper and the fake memory.
- Image layout: header word at base, elements row-major at base+1 .. base+rows*cols.
- Header is written last, so a valid header marks the matrix as committed.
- Sits between the compute datapath output and the memory controller.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/matrix_writer_element_counter.sv | 42 ++++
 rtl/matrix_writer.sv | 169 ++++++++++++++++
 tb/tb_matrix_writer.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared types for the matrix store/load engines.
//   matrix_header_t : layout of the header word written at the image base address
//   writer_state_t  : store-engine FSM states
//   HDR_OFFSET      : distance from the header word to the first element
package matrix_pkg;

  localparam int unsigned HDR_OFFSET = 1;

  typedef struct packed {
    logic [3:0]  tag;
    logic [6:0]  rows;
    logic [6:0]  cols;
    logic [13:0] rsvd;
  } matrix_header_t;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StHeader,
    StDone
  } writer_state_t;

endpackage

// File: rtl/matrix_writer_element_counter.sv
// Loadable up-counter with a terminal-count compare.
//   clock_i, reset_i : clock, async active-high reset
//   clear_i          : reload the count to zero (wins over inc_i)
//   inc_i            : advance the count by one
//   total_i          : number of elements in the current transfer
//   count_o          : current element index
//   last_o           : count_o is the final index (total_i - 1)
module matrix_writer_element_counter #(
  parameter int unsigned Width = 14
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             inc_i,
  input  logic [Width-1:0] total_i,
  output logic [Width-1:0] count_o,
  output logic             last_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == total_i - Width'(1));

endmodule

// File: rtl/matrix_writer.sv
// Store engine: streams rows*cols elements into word-addressed memory at base+1..base+total,
// then writes the header word at base so a valid header marks the image as committed.
//   clock_i, reset_i        : clock, async active-high reset
//   start_i                 : store request, only honoured while idle
//   base_addr_i, rows_i,
//   cols_i, tag_i           : image geometry, captured on an accepted start
//   in_valid_i, in_data_i,
//   in_ready_o              : element stream handshake
//   read_o, write_o,
//   address_o, writedata_o  : memory initiator port (registered, write-only)
//   busy_o                  : a store is in progress
//   done_o                  : one-cycle pulse after the header write
//   error_o                 : one-cycle pulse after a rejected start
module matrix_writer
  import matrix_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DIM_WIDTH  = 7
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [DIM_WIDTH-1:0]  rows_i,
  input  logic [DIM_WIDTH-1:0]  cols_i,
  input  logic [3:0]            tag_i,
  input  logic                  in_valid_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  output logic                  in_ready_o,
  output logic                  read_o,
  output logic                  write_o,
  output logic [ADDR_WIDTH-1:0] address_o,
  output logic [DATA_WIDTH-1:0] writedata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  error_o
);

  localparam int unsigned TotW = 2 * DIM_WIDTH;
  localparam int unsigned ChkW = ADDR_WIDTH + TotW;

  writer_state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] base_q;
  logic [DIM_WIDTH-1:0]  rows_q, cols_q;
  logic [3:0]            tag_q;
  logic [TotW-1:0]       total_q;

  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic [DATA_WIDTH-1:0] writedata_q, writedata_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic [TotW-1:0] total_w;
  logic [ChkW-1:0] end_addr_w;
  logic            start_ok_w, accept_w, reject_w, hs_w;
  logic [TotW-1:0] idx_w;
  logic            idx_last_w;
  matrix_header_t  hdr_w;

  // Last image address (base + total) must stay inside memory; checked wide so it cannot wrap.
  assign total_w    = TotW'(rows_i) * TotW'(cols_i);
  assign end_addr_w = ChkW'(base_addr_i) + ChkW'(total_w);
  assign start_ok_w = (rows_i != '0) && (cols_i != '0) &&
                      (end_addr_w <= ChkW'({ADDR_WIDTH{1'b1}}));
  assign accept_w   = (state_q == StIdle) && start_i && start_ok_w;
  assign reject_w   = (state_q == StIdle) && start_i && !start_ok_w;
  assign hs_w       = in_valid_i && in_ready_o;

  assign hdr_w = '{tag: tag_q, rows: 7'(rows_q), cols: 7'(cols_q), rsvd: '0};

  matrix_writer_element_counter #(
    .Width (TotW)
  ) u_counter (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .clear_i (accept_w),
    .inc_i   (hs_w),
    .total_i (total_q),
    .count_o (idx_w),
    .last_o  (idx_last_w)
  );

  // State and captured-field register.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      base_q      <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      tag_q       <= '0;
      total_q     <= '0;
      write_q     <= 1'b0;
      address_q   <= '0;
      writedata_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      write_q     <= write_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      done_q      <= done_d;
      error_q     <= error_d;
      if (accept_w) begin
        base_q  <= base_addr_i;
        rows_q  <= rows_i;
        cols_q  <= cols_i;
        tag_q   <= tag_i;
        total_q <= total_w;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept_w) state_d = StData;
      StData:   if (hs_w && idx_last_w) state_d = StHeader;
      StHeader: state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Output logic: next values of the registered memory port and status pulses.
  always_comb begin
    write_d     = 1'b0;
    address_d   = address_q;
    writedata_d = writedata_q;
    done_d      = 1'b0;
    error_d     = 1'b0;
    in_ready_o  = 1'b0;
    unique case (state_q)
      StIdle: begin
        error_d = reject_w;
      end
      StData: begin
        in_ready_o = 1'b1;
        if (hs_w) begin
          write_d     = 1'b1;
          address_d   = base_q + ADDR_WIDTH'(HDR_OFFSET) + ADDR_WIDTH'(idx_w);
          writedata_d = in_data_i;
        end
      end
      StHeader: begin
        write_d     = 1'b1;
        address_d   = base_q;
        writedata_d = DATA_WIDTH'(hdr_w);
      end
      StDone: begin
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  assign read_o      = 1'b0;
  assign write_o     = write_q;
  assign address_o   = address_q;
  assign writedata_o = writedata_q;
  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign error_o     = error_q;

endmodule

// File: tb/tb_matrix_writer.sv
module tb_matrix_writer;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [7:0]  base_addr_i;
  logic [6:0]  rows_i, cols_i;
  logic [3:0]  tag_i;
  logic        in_valid_i;
  logic [31:0] in_data_i;
  logic        in_ready_o, read_o, write_o, busy_o, done_o, error_o;
  logic [7:0]  address_o;
  logic [31:0] writedata_o;

  matrix_writer #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .DIM_WIDTH  (7)
  ) dut (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .rows_i      (rows_i),
    .cols_i      (cols_i),
    .tag_i       (tag_i),
    .in_valid_i  (in_valid_i),
    .in_data_i   (in_data_i),
    .in_ready_o  (in_ready_o),
    .read_o      (read_o),
    .write_o     (write_o),
    .address_o   (address_o),
    .writedata_o (writedata_o),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .error_o     (error_o)
  );

  always #5 clock_i = ~clock_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] hdr_word(input int tag, input int rows, input int cols);
    logic [31:0] t, r, c;
    t = 32'(tag);
    r = 32'(rows);
    c = 32'(cols);
    return (t << 28) | (r << 21) | (c << 14);
  endfunction

  function automatic bit fits(input int base, input int rows, input int cols);
    return (rows != 0) && (cols != 0) && (base + rows * cols <= 255);
  endfunction

  // Memory image as seen through the DUT's write port.
  logic [31:0] obs_mem [256];
  int          wr_count = 0;
  int          last_wr_addr = -1;

  // Reference model: job description plus progress, advanced once per clock edge.
  bit          m_busy = 0;
  int          m_phase = 0;  // 0 collecting elements, 1 header next, 2 commit next
  int          m_base, m_rows, m_cols, m_tag, m_total, m_recv;
  bit          e_write, e_done, e_error;
  int          e_addr;
  logic [31:0] e_data;

  always @(posedge clock_i) begin
    e_write = 0; e_done = 0; e_error = 0; e_addr = 0; e_data = '0;
    if (reset_i) begin
      m_busy  = 0;
      m_phase = 0;
    end else begin
      chk("in_ready", {31'b0, in_ready_o}, {31'b0, (m_busy && m_phase == 0)});
      if (!m_busy) begin
        if (start_i) begin
          if (!fits(int'(base_addr_i), int'(rows_i), int'(cols_i))) begin
            e_error = 1;
          end else begin
            m_busy  = 1;
            m_phase = 0;
            m_base  = int'(base_addr_i);
            m_rows  = int'(rows_i);
            m_cols  = int'(cols_i);
            m_tag   = int'(tag_i);
            m_total = m_rows * m_cols;
            m_recv  = 0;
          end
        end
      end else if (m_phase == 0) begin
        if (in_valid_i) begin
          e_write = 1;
          e_addr  = m_base + 1 + m_recv;
          e_data  = in_data_i;
          m_recv++;
          if (m_recv == m_total) m_phase = 1;
        end
      end else if (m_phase == 1) begin
        e_write = 1;
        e_addr  = m_base;
        e_data  = hdr_word(m_tag, m_rows, m_cols);
        m_phase = 2;
      end else begin
        e_done = 1;
        m_busy = 0;
      end
    end
    #1;
    chk("read", {31'b0, read_o}, 32'd0);
    chk("write", {31'b0, write_o}, {31'b0, e_write});
    chk("done", {31'b0, done_o}, {31'b0, e_done});
    chk("error", {31'b0, error_o}, {31'b0, e_error});
    chk("busy", {31'b0, busy_o}, {31'b0, m_busy});
    if (e_write && write_o) begin
      chk("address", {24'b0, address_o}, 32'(e_addr));
      chk("writedata", writedata_o, e_data);
    end
    if (write_o) begin
      obs_mem[address_o] = writedata_o;
      wr_count++;
      last_wr_addr = int'(address_o);
    end
  end

  logic [31:0] flt [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                           32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] elems [$];

  task automatic idle(input int n);
    repeat (n) @(negedge clock_i);
  endtask

  // Called at a negedge. vmode: 0 valid held, 1 pattern 1,0,0, 2 random.
  task automatic send_store(input int base, input int rows, input int cols, input int tag,
                            input bit use_flt, input int vmode, input int abort_after,
                            input bit inject);
    int  total, sent, cyc, budget;
    bit  v, hs, injected;
    total = rows * cols;
    sent = 0; cyc = 0; injected = 0;
    elems.delete();
    for (int i = 0; i < total; i++) elems.push_back(use_flt ? flt[i % 6] : $urandom);
    start_i = 1; base_addr_i = 8'(base); rows_i = 7'(rows); cols_i = 7'(cols); tag_i = 4'(tag);
    @(negedge clock_i);
    start_i = 0;
    while (sent < total && cyc < 400) begin
      if (abort_after > 0 && sent == abort_after) break;
      v = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
      in_valid_i = v;
      in_data_i  = v ? elems[sent] : $urandom;
      if (inject && sent == 2 && !injected) begin
        start_i = 1; base_addr_i = 8'd40; injected = 1;
      end
      hs = v && in_ready_o;
      @(negedge clock_i);
      start_i = 0; base_addr_i = 8'(base);
      if (hs) sent++;
      cyc++;
    end
    in_valid_i = 0;
    if (abort_after > 0) begin
      #2 reset_i = 1;
      #1;
      chk("abort write", {31'b0, write_o}, 32'd0);
      chk("abort busy", {31'b0, busy_o}, 32'd0);
      chk("abort in_ready", {31'b0, in_ready_o}, 32'd0);
      chk("abort address", {24'b0, address_o}, 32'd0);
      chk("abort writedata", writedata_o, 32'd0);
      @(negedge clock_i);
      reset_i = 0;
      return;
    end
    chk("elements accepted", 32'(sent), 32'(total));
    budget = 0;
    while (!done_o && budget < 10) begin
      @(negedge clock_i);
      budget++;
    end
    chk("done reached", {31'b0, done_o}, 32'd1);
    for (int i = 0; i < total; i++) chk("mem elem", obs_mem[base + 1 + i], elems[i]);
    chk("mem header", obs_mem[base], hdr_word(tag, rows, cols));
  endtask

  task automatic do_reject(input int base, input int rows, input int cols);
    int wc;
    wc = wr_count;
    start_i = 1; base_addr_i = 8'(base); rows_i = 7'(rows); cols_i = 7'(cols); tag_i = 4'hF;
    @(negedge clock_i);
    start_i = 0;
    chk("reject error", {31'b0, error_o}, 32'd1);
    chk("reject busy", {31'b0, busy_o}, 32'd0);
    @(negedge clock_i);
    chk("reject error clears", {31'b0, error_o}, 32'd0);
    chk("reject no write", 32'(wr_count - wc), 32'd0);
  endtask

  initial begin
    int wc, b, r, c;
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc, b, r, c;
    for (int i = 0; i < 256; i++) obs_mem[i] = 32'hDEADBEEF;
    reset_i = 1; start_i = 0; base_addr_i = '0; rows_i = '0; cols_i = '0; tag_i = '0;
    in_valid_i = 0; in_data_i = '0;
    repeat (3) @(negedge clock_i);
    chk("reset write", {31'b0, write_o}, 32'd0);
    chk("reset busy", {31'b0, busy_o}, 32'd0);
    chk("reset done", {31'b0, done_o}, 32'd0);
    chk("reset error", {31'b0, error_o}, 32'd0);
    chk("reset address", {24'b0, address_o}, 32'd0);
    chk("reset writedata", writedata_o, 32'd0);
    reset_i = 0;
    idle(2);

    // 2x3 store with valid held high.
    wc = wr_count;
    send_store(8, 2, 3, 1, 1, 0, 0, 0);
    chk("2x3 header literal", obs_mem[8], 32'h1040C000);
    chk("2x3 first elem", obs_mem[9], 32'h3F800000);
    chk("2x3 last elem", obs_mem[14], 32'h40C00000);
    chk("2x3 write count", 32'(wr_count - wc), 32'd7);
    chk("2x3 header last", 32'(last_wr_addr), 32'd8);
    idle(2);

    // Same store under backpressure.
    for (int i = 8; i <= 14; i++) obs_mem[i] = 32'hDEADBEEF;
    wc = wr_count;
    send_store(8, 2, 3, 1, 1, 1, 0, 0);
    chk("bp write count", 32'(wr_count - wc), 32'd7);
    chk("bp header last", 32'(last_wr_addr), 32'd8);
    idle(2);

    // Rejected starts and the exact-fit boundary.
    do_reject(0, 0, 3);
    do_reject(250, 2, 3);
    wc = wr_count;
    send_store(249, 2, 3, 2, 0, 0, 0, 0);
    chk("edge last addr elem", obs_mem[255], elems[5]);
    chk("edge write count", 32'(wr_count - wc), 32'd7);
    idle(1);

    // Start while busy is ignored.
    for (int i = 40; i <= 46; i++) obs_mem[i] = 32'hDEADBEEF;
    wc = wr_count;
    send_store(100, 2, 3, 3, 0, 0, 0, 1);
    chk("busy start write count", 32'(wr_count - wc), 32'd7);
    chk("busy start base untouched", obs_mem[40], 32'hDEADBEEF);
    idle(2);

    // Reset after three elements, then a clean restart.
    wc = wr_count;
    send_store(60, 2, 3, 4, 0, 0, 3, 0);
    chk("abort writes", 32'(wr_count - wc), 32'd3);
    chk("abort no header", obs_mem[60], 32'hDEADBEEF);
    idle(1);
    send_store(60, 2, 3, 4, 0, 2, 0, 0);
    idle(1);

    // Back-to-back: second start in the done cycle.
    wc = wr_count;
    send_store(20, 2, 2, 5, 0, 0, 0, 0);
    send_store(30, 3, 1, 6, 0, 0, 0, 0);
    chk("b2b write count", 32'(wr_count - wc), 32'd9);

    // Randomized stores and rejects.
    for (int n = 0; n < 14; n++) begin
      idle($urandom_range(0, 2));
      b = $urandom_range(0, 255);
      r = $urandom_range(0, 5);
      c = $urandom_range(0, 5);
      if (fits(b, r, c)) send_store(b, r, c, $urandom_range(0, 15), 0, 2, 0, 0);
      else do_reject(b, r, c);
    end
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
